// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - phase tracker and sequence checker for a 5-bit one-hot ring
// Optional revolution counter enabled by defining RING_MON_REV_COUNT_EN.
module ring_phase_monitor #(
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             preset,
    input  logic [4:0]       ring,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_wrap,
    output logic             fault,
    output logic [4:0]       err_pattern
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    state_t     state;
    logic [4:0] prev;
    logic       one_hot;
    logic [2:0] hot_idx;
    logic [4:0] rot;

    always_comb begin
        one_hot = $onehot(ring);
        hot_idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (ring[i]) hot_idx = 3'(i);
        end
        // Upstream shifter moves bit i to bit i+1, bit 4 wraps to bit 0.
        rot = {prev[3:0], prev[4]};
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            prev        <= 5'd0;
            phase       <= 3'd0;
            phase_valid <= 1'b0;
            fault       <= 1'b0;
            err_pattern <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ring == 5'd0) begin
                        phase_valid <= 1'b0;
                    end else if (one_hot) begin
                        state       <= TRACK;
                        phase       <= hot_idx;
                        phase_valid <= 1'b1;
                        prev        <= ring;
                    end else begin
                        state       <= FAULT;
                        fault       <= 1'b1;
                        err_pattern <= ring;
                    end
                end
                TRACK: begin
                    if (ring == prev) begin
                        state <= TRACK;
                    end else if (ring == rot) begin
                        phase <= (phase == 3'd4) ? 3'd0 : phase + 3'd1;
                        prev  <= ring;
                    end else if (ring == 5'd0) begin
                        state       <= IDLE;
                        phase       <= 3'd0;
                        phase_valid <= 1'b0;
                        prev        <= 5'd0;
                    end else begin
                        state       <= FAULT;
                        phase       <= 3'd0;
                        phase_valid <= 1'b0;
                        prev        <= 5'd0;
                        fault       <= 1'b1;
                        err_pattern <= ring;
                    end
                end
                FAULT: begin
                    if (clr_err) begin
                        state       <= IDLE;
                        fault       <= 1'b0;
                        err_pattern <= 5'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RING_MON_REV_COUNT_EN
    logic rev_bump;

    // A revolution completes on the legal advance out of bit 4 into bit 0.
    assign rev_bump = (state == TRACK) && (ring != prev) && (ring == rot) && prev[4];

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            rev_count <= '0;
            rev_wrap  <= 1'b0;
        end else begin
            rev_wrap <= rev_bump && (&rev_count);
            if (rev_bump) rev_count <= rev_count + 1'b1;
        end
    end
`else
    assign rev_count = '0;
    assign rev_wrap  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - self-checking bench for ring_phase_monitor
module tb_ring_phase_monitor;
    localparam int REV_W = 2;
`ifdef RING_MON_REV_COUNT_EN
    localparam int REV_EN = 1;
`else
    localparam int REV_EN = 0;
`endif

    logic             clk = 1'b0;
    logic             preset = 1'b0;
    logic [4:0]       ring = 5'd0;
    logic             clr_err = 1'b0;
    logic [2:0]       phase;
    logic             phase_valid;
    logic [REV_W-1:0] rev_count;
    logic             rev_wrap;
    logic             fault;
    logic [4:0]       err_pattern;

    int checks = 0;
    int failures = 0;

    ring_phase_monitor #(.REV_W(REV_W)) dut (
        .clk(clk), .preset(preset), .ring(ring), .clr_err(clr_err),
        .phase(phase), .phase_valid(phase_valid), .rev_count(rev_count),
        .rev_wrap(rev_wrap), .fault(fault), .err_pattern(err_pattern)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        ring = 5'd0;
        clr_err = 1'b0;
        #2;
        preset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [4:0] ring;
        logic       clr;
        int         ph;
        int         vld;
        int         rev;
        int         flt;
        int         err;
    } vec_t;
    vec_t tbl[$];

    // Reference model: tracks the hot index and revolution count numerically.
    int m_mode, m_idx, m_rev, m_wrap, m_fault, m_err;

    function automatic int hot_of(input logic [4:0] r);
        int n = 0;
        int k = -1;
        for (int i = 0; i < 5; i++) if (r[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_rev = 0; m_wrap = 0; m_fault = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [4:0] r, input logic c);
        int h;
        h = hot_of(r);
        m_wrap = 0;
        case (m_mode)
            0: begin
                if (r == 0) m_mode = 0;
                else if (h >= 0) begin m_mode = 1; m_idx = h; end
                else begin m_mode = 2; m_fault = 1; m_err = int'(r); end
            end
            1: begin
                if (r == 0) m_mode = 0;
                else if (h == m_idx) m_mode = 1;
                else if (h >= 0 && h == (m_idx + 1) % 5) begin
                    if (m_idx == 4 && REV_EN == 1) begin
                        if (m_rev == (1 << REV_W) - 1) m_wrap = 1;
                        m_rev = (m_rev + 1) % (1 << REV_W);
                    end
                    m_idx = h;
                end else begin m_mode = 2; m_fault = 1; m_err = int'(r); end
            end
            default: begin
                if (c) begin m_mode = 0; m_fault = 0; m_err = 0; end
            end
        endcase
    endtask

    initial begin
        int exp_rev;
        logic [4:0] last;
        #1;
        // Reset state
        preset = 1'b1;
        #3;
        chk("reset_phase", int'(phase), 0);
        chk("reset_valid", int'(phase_valid), 0);
        chk("reset_rev", int'(rev_count), 0);
        chk("reset_wrap", int'(rev_wrap), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_err", int'(err_pattern), 0);
        preset = 1'b0;
        step();

        // Rotation, stall, skip fault, clear, multi-hot fault
        tbl.push_back('{5'b00001, 1'b0, 0, 1, 0, 0, 0});
        tbl.push_back('{5'b00010, 1'b0, 1, 1, 0, 0, 0});
        tbl.push_back('{5'b00100, 1'b0, 2, 1, 0, 0, 0});
        tbl.push_back('{5'b01000, 1'b0, 3, 1, 0, 0, 0});
        tbl.push_back('{5'b10000, 1'b0, 4, 1, 0, 0, 0});
        tbl.push_back('{5'b00001, 1'b0, 0, 1, 1, 0, 0});
        tbl.push_back('{5'b00010, 1'b0, 1, 1, 1, 0, 0});
        tbl.push_back('{5'b00100, 1'b1, 2, 1, 1, 0, 0});
        tbl.push_back('{5'b00100, 1'b0, 2, 1, 1, 0, 0});
        tbl.push_back('{5'b00100, 1'b0, 2, 1, 1, 0, 0});
        tbl.push_back('{5'b01000, 1'b0, 3, 1, 1, 0, 0});
        tbl.push_back('{5'b10000, 1'b0, 4, 1, 1, 0, 0});
        tbl.push_back('{5'b00001, 1'b0, 0, 1, 2, 0, 0});
        tbl.push_back('{5'b00010, 1'b0, 1, 1, 2, 0, 0});
        tbl.push_back('{5'b01000, 1'b0, 0, 0, 2, 1, 8});
        tbl.push_back('{5'b10000, 1'b0, 0, 0, 2, 1, 8});
        tbl.push_back('{5'b00100, 1'b1, 0, 0, 2, 0, 0});
        tbl.push_back('{5'b00011, 1'b0, 0, 0, 2, 1, 3});
        tbl.push_back('{5'b00110, 1'b0, 0, 0, 2, 1, 3});
        tbl.push_back('{5'b01100, 1'b0, 0, 0, 2, 1, 3});
        tbl.push_back('{5'b11000, 1'b0, 0, 0, 2, 1, 3});
        tbl.push_back('{5'b00000, 1'b1, 0, 0, 2, 0, 0});
        tbl.push_back('{5'b00001, 1'b0, 0, 1, 2, 0, 0});
        tbl.push_back('{5'b00000, 1'b0, 0, 0, 2, 0, 0});
        foreach (tbl[i]) begin
            ring = tbl[i].ring;
            clr_err = tbl[i].clr;
            step();
            if (tbl[i].vld == 1) chk($sformatf("tbl%0d_phase", i), int'(phase), tbl[i].ph);
            chk($sformatf("tbl%0d_valid", i), int'(phase_valid), tbl[i].vld);
            chk($sformatf("tbl%0d_rev", i), int'(rev_count), tbl[i].rev * REV_EN);
            chk($sformatf("tbl%0d_wrap", i), int'(rev_wrap), 0);
            chk($sformatf("tbl%0d_fault", i), int'(fault), tbl[i].flt);
            chk($sformatf("tbl%0d_err", i), int'(err_pattern), tbl[i].err);
        end
        clr_err = 1'b0;

        // Four full revolutions with a 2-bit counter
        do_reset();
        ring = 5'b00001;
        step();
        exp_rev = 0;
        for (int i = 1; i <= 20; i++) begin
            int exp_wrap;
            ring = 5'(1 << (i % 5));
            step();
            exp_wrap = 0;
            if (i % 5 == 0 && REV_EN == 1) begin
                if (exp_rev == 3) exp_wrap = 1;
                exp_rev = (exp_rev + 1) % 4;
            end
            chk($sformatf("wrap_rev%0d", i), int'(rev_count), exp_rev);
            chk($sformatf("wrap_pulse%0d", i), int'(rev_wrap), exp_wrap);
        end
        ring = 5'b00010;
        step();
        chk("wrap_pulse_after", int'(rev_wrap), 0);

        // Asynchronous reset in TRACK at phase 3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ring = 5'(1 << i);
            step();
        end
        chk("async_pre_phase", int'(phase), 3);
        #2;
        preset = 1'b1;
        #1;
        chk("async_phase", int'(phase), 0);
        chk("async_valid", int'(phase_valid), 0);
        chk("async_rev", int'(rev_count), 0);
        chk("async_fault", int'(fault), 0);
        chk("async_err", int'(err_pattern), 0);
        step();
        preset = 1'b0;
        ring = 5'b00010;
        step();
        chk("async_restart_phase", int'(phase), 1);
        chk("async_restart_valid", int'(phase_valid), 1);
        chk("async_restart_fault", int'(fault), 0);

        // Randomised run against the reference model
        do_reset();
        model_reset();
        last = 5'b00001;
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            clr_err = 1'b0;
            if (sel <= 4) begin
                last = {last[3:0], last[4]};
                if (last == 5'd0) last = 5'b00001;
            end else if (sel <= 6) begin
                if (last == 5'd0) last = 5'b00001;
            end else if (sel == 7) begin
                last = 5'd0;
            end else if (sel == 8) begin
                last = 5'($urandom_range(0, 31));
            end else if (sel == 9) begin
                last = 5'(1 << $urandom_range(0, 4));
            end else begin
                clr_err = 1'b1;
            end
            ring = last;
            step();
            model_step(ring, clr_err);
            if (m_mode == 1) chk("rnd_phase", int'(phase), m_idx);
            chk("rnd_valid", int'(phase_valid), (m_mode == 1) ? 1 : 0);
            chk("rnd_rev", int'(rev_count), m_rev);
            chk("rnd_wrap", int'(rev_wrap), m_wrap);
            chk("rnd_fault", int'(fault), m_fault);
            chk("rnd_err", int'(err_pattern), m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
